fpu_div_arbiter: RTL and testbench

Controller that shares one iterative FP divide/square-root unit between the three FPU issue lanes (u1/u3/u5) of the FP backend. It accepts divide/sqrt requests with a valid/ready handshake and grants them round-robin. It starts the shared unit, tracks its fixed latency with a down-counter, and returns a completion pulse plus retire tag to the originating lane. It also handles lane flush of the in-flight operation.

---
 rtl/fp_div_pkg.sv | 17 +
 rtl/rr_arb3.sv | 45 ++++
 rtl/fpu_div_arbiter.sv | 132 +++++++++++++
 tb/tb_fpu_div_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and constants for the FP divide/sqrt arbiter
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LANE_U1 = 0;
  localparam int LANE_U3 = 1;
  localparam int LANE_U5 = 2;

  localparam int DIV_LAT_D_DEF = 28;
  localparam int DIV_LAT_S_DEF = 14;

endpackage

// File: rtl/rr_arb3.sv
// rtl/rr_arb3.sv - combinational 3-way round-robin arbiter
module rr_arb3
  import fp_div_pkg::*;
(
  input  logic [2:0] req,
  input  logic       en,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] next_ptr
);

  logic [2:0] rot;
  logic [2:0] g_rot;

  // Rotate so the lane named by ptr sits in bit 0, pick lowest set bit, rotate back
  always_comb begin
    rot   = 3'b000;
    g_rot = 3'b000;
    gnt   = 3'b000;
    if (en) begin
      case (ptr)
        2'd1:    rot = {req[0], req[2], req[1]};
        2'd2:    rot = {req[1], req[0], req[2]};
        default: rot = req;
      endcase
    end
    if (rot[0])      g_rot = 3'b001;
    else if (rot[1]) g_rot = 3'b010;
    else if (rot[2]) g_rot = 3'b100;
    case (ptr)
      2'd1:    gnt = {g_rot[1], g_rot[0], g_rot[2]};
      2'd2:    gnt = {g_rot[0], g_rot[2], g_rot[1]};
      default: gnt = g_rot;
    endcase
  end

  // Pointer moves to the lane after the winner, wrapping u5 back to u1
  always_comb begin
    next_ptr = ptr;
    if (gnt[LANE_U1])      next_ptr = 2'd1;
    else if (gnt[LANE_U3]) next_ptr = 2'd2;
    else if (gnt[LANE_U5]) next_ptr = 2'd0;
  end

endmodule

// File: rtl/fpu_div_arbiter.sv
// rtl/fpu_div_arbiter.sv - shares one iterative FP div/sqrt unit among three issue lanes
module fpu_div_arbiter
  import fp_div_pkg::*;
#(
  parameter int DIV_LAT_D = DIV_LAT_D_DEF,
  parameter int DIV_LAT_S = DIV_LAT_S_DEF,
  parameter int TAG_W     = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req_valid,
  input  logic [2:0]       req_dbl,
  input  logic [2:0]       req_sqrt,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  input  logic [TAG_W-1:0] req_tag2,
  output logic [2:0]       req_ready,
  input  logic             flush,
  input  logic [2:0]       flush_lane,
  output logic             div_start,
  output logic             div_dbl,
  output logic             div_sqrt,
  output logic             div_abort,
  output logic             busy,
  output logic [2:0]       ret_en,
  output logic [TAG_W-1:0] ret_tag
);

  localparam int CNT_W = $clog2((DIV_LAT_D > DIV_LAT_S) ? DIV_LAT_D : DIV_LAT_S);
  localparam logic [CNT_W-1:0] LOAD_D = CNT_W'(DIV_LAT_D - 1);
  localparam logic [CNT_W-1:0] LOAD_S = CNT_W'(DIV_LAT_S - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q;
  logic [1:0]       next_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       lane_q;
  logic [TAG_W-1:0] tag_q;
  logic             dbl_q, sqrt_q;
  logic             start_q, abort_q;

  logic [2:0]       req_masked;
  logic [2:0]       gnt;
  logic             grant;
  logic             arb_en;
  logic             flush_hit;
  logic [TAG_W-1:0] tag_sel;

  // A lane being flushed this cycle must not win the unit
  assign req_masked = req_valid & ~(flush ? flush_lane : 3'b000);
  assign arb_en     = (state_q == IDLE) || (state_q == DONE);
  assign grant      = |gnt;
  assign req_ready  = gnt;
  assign flush_hit  = flush && |(flush_lane & lane_q);

  rr_arb3 u_arb (
    .req      (req_masked),
    .en       (arb_en),
    .ptr      (ptr_q),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  // Pick the retire tag of the winning lane
  always_comb begin
    tag_sel = '0;
    if (gnt[LANE_U1])      tag_sel = req_tag0;
    else if (gnt[LANE_U3]) tag_sel = req_tag1;
    else if (gnt[LANE_U5]) tag_sel = req_tag2;
  end

  // Next-state logic; an abort in BUSY wins over reaching the last count
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = BUSY;
      BUSY: begin
        if (flush_hit)            state_d = IDLE;
        else if (cnt_q == '0)     state_d = DONE;
      end
      DONE:    state_d = grant ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request latches, round-robin pointer and latency down-counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= 2'd0;
      cnt_q  <= '0;
      lane_q <= 3'b000;
      tag_q  <= '0;
      dbl_q  <= 1'b0;
      sqrt_q <= 1'b0;
    end else if (grant) begin
      ptr_q  <= next_ptr;
      cnt_q  <= (|(gnt & req_dbl)) ? LOAD_D : LOAD_S;
      lane_q <= gnt;
      tag_q  <= tag_sel;
      dbl_q  <= |(gnt & req_dbl);
      sqrt_q <= |(gnt & req_sqrt);
    end else if (state_q == BUSY && cnt_q != '0) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // One-cycle start and abort pulses to the shared unit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      start_q <= grant;
      abort_q <= (state_q == BUSY) && flush_hit;
    end
  end

  assign div_start = start_q;
  assign div_abort = abort_q;
  assign busy      = (state_q == BUSY);
  assign div_dbl   = busy && dbl_q;
  assign div_sqrt  = busy && sqrt_q;
  assign ret_en    = (state_q == DONE) ? lane_q : 3'b000;
  assign ret_tag   = (state_q == DONE) ? tag_q : '0;

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// tb/tb_fpu_div_arbiter.sv - directed self-checking bench for fpu_div_arbiter
module tb_fpu_div_arbiter;

  localparam int TAG_W = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req_valid, req_dbl, req_sqrt;
  logic [TAG_W-1:0] req_tag0, req_tag1, req_tag2;
  logic [2:0]       req_ready;
  logic             flush;
  logic [2:0]       flush_lane;
  logic             div_start, div_dbl, div_sqrt, div_abort, busy;
  logic [2:0]       ret_en;
  logic [TAG_W-1:0] ret_tag;

  int errors = 0;
  int checks = 0;

  fpu_div_arbiter #(.DIV_LAT_D(28), .DIV_LAT_S(14), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_dbl    (req_dbl),
    .req_sqrt   (req_sqrt),
    .req_tag0   (req_tag0),
    .req_tag1   (req_tag1),
    .req_tag2   (req_tag2),
    .req_ready  (req_ready),
    .flush      (flush),
    .flush_lane (flush_lane),
    .div_start  (div_start),
    .div_dbl    (div_dbl),
    .div_sqrt   (div_sqrt),
    .div_abort  (div_abort),
    .busy       (busy),
    .ret_en     (ret_en),
    .ret_tag    (ret_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle_inputs();
    req_valid  = 3'b000;
    req_dbl    = 3'b000;
    req_sqrt   = 3'b000;
    flush      = 1'b0;
    flush_lane = 3'b000;
  endtask

  int bad;
  logic [TAG_W-1:0] rr_tag [3];

  initial begin
    rst = 1'b0;
    idle_inputs();
    req_tag0 = '0; req_tag1 = '0; req_tag2 = '0;
    step(3);
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_start", 32'(div_start), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_ret",   32'(ret_en),    32'h0);
    chk("rst_tag",   32'(ret_tag),   32'h0);
    chk("rst_abort", 32'(div_abort), 32'h0);
    rst = 1'b1;
    step(2);

    // single double-precision divide on lane 1
    req_valid = 3'b010; req_dbl = 3'b010; req_tag1 = 14'h155;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h2);
    step(1);
    idle_inputs();
    #1;
    chk("t1_start", 32'(div_start), 32'h1);
    chk("t1_dbl",   32'(div_dbl),   32'h1);
    chk("t1_busy",  32'(busy),      32'h1);
    step(27);
    #1;
    chk("t1_busy_last", 32'(busy),   32'h1);
    chk("t1_no_ret",    32'(ret_en), 32'h0);
    step(1);
    #1;
    chk("t1_ret",     32'(ret_en),  32'h2);
    chk("t1_ret_tag", 32'(ret_tag), 32'h155);
    chk("t1_done_busy", 32'(busy),  32'h0);
    step(1);
    #1;
    chk("t1_ret_once", 32'(ret_en), 32'h0);

    // single-precision sqrt on lane 2
    req_valid = 3'b100; req_sqrt = 3'b100; req_tag2 = 14'h2AA;
    #1;
    chk("t2_ready", 32'(req_ready), 32'h4);
    step(1);
    idle_inputs();
    #1;
    chk("t2_start", 32'(div_start), 32'h1);
    chk("t2_sqrt",  32'(div_sqrt),  32'h1);
    chk("t2_dbl",   32'(div_dbl),   32'h0);
    step(13);
    #1;
    chk("t2_no_ret", 32'(ret_en), 32'h0);
    step(1);
    #1;
    chk("t2_ret",     32'(ret_en),  32'h4);
    chk("t2_ret_tag", 32'(ret_tag), 32'h2AA);

    // round robin from reset, all lanes requesting continuously
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    rr_tag[0] = 14'h011; rr_tag[1] = 14'h022; rr_tag[2] = 14'h033;
    req_tag0 = rr_tag[0]; req_tag1 = rr_tag[1]; req_tag2 = rr_tag[2];
    req_valid = 3'b111;
    #1;
    chk("rr_first", 32'(req_ready), 32'h1);
    step(1);
    #1;
    chk("rr_start0", 32'(div_start), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(14);
      #1;
      chk("rr_ret",   32'(ret_en),    32'(1 << i));
      chk("rr_tag",   32'(ret_tag),   32'(rr_tag[i]));
      chk("rr_grant", 32'(req_ready), 32'(1 << ((i + 1) % 3)));
      chk("rr_done_busy", 32'(busy),  32'h0);
      step(1);
      #1;
      chk("rr_b2b_start", 32'(div_start), 32'h1);
    end
    req_valid = 3'b000;
    step(13);
    #1;
    chk("rr_wrap_wait", 32'(ret_en), 32'h0);
    step(1);
    #1;
    chk("rr_wrap_ret", 32'(ret_en),  32'h1);
    chk("rr_wrap_tag", 32'(ret_tag), 32'h011);
    step(1);

    // flush of the in-flight lane 1, lane 2 waiting
    req_valid = 3'b010; req_dbl = 3'b010; req_tag1 = 14'h1AB;
    #1;
    chk("fl_ready", 32'(req_ready), 32'h2);
    step(1);
    idle_inputs();
    req_valid = 3'b100; req_tag2 = 14'h0CC;
    #1;
    chk("fl_start", 32'(div_start), 32'h1);
    chk("fl_busy_ready", 32'(req_ready), 32'h0);
    step(5);
    flush = 1'b1; flush_lane = 3'b010;
    #1;
    chk("fl_no_abort_yet", 32'(div_abort), 32'h0);
    step(1);
    flush = 1'b0; flush_lane = 3'b000;
    #1;
    chk("fl_abort",   32'(div_abort), 32'h1);
    chk("fl_idle",    32'(busy),      32'h0);
    chk("fl_no_ret",  32'(ret_en),    32'h0);
    chk("fl_grant2",  32'(req_ready), 32'h4);
    step(1);
    req_valid = 3'b000;
    #1;
    chk("fl_start2",   32'(div_start), 32'h1);
    chk("fl_abort_1c", 32'(div_abort), 32'h0);
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      step(1);
      #1;
      if (ret_en != 3'b000) bad++;
    end
    chk("fl_quiet", 32'(bad), 32'h0);
    step(1);
    #1;
    chk("fl_ret2",     32'(ret_en),  32'h4);
    chk("fl_ret2_tag", 32'(ret_tag), 32'h0CC);
    step(1);

    // flush aimed at another lane leaves lane 1 alone
    req_valid = 3'b010; req_tag1 = 14'h077;
    #1;
    chk("fo_ready", 32'(req_ready), 32'h2);
    step(1);
    idle_inputs();
    step(3);
    flush = 1'b1; flush_lane = 3'b001;
    step(1);
    flush = 1'b0; flush_lane = 3'b000;
    #1;
    chk("fo_no_abort", 32'(div_abort), 32'h0);
    chk("fo_busy",     32'(busy),      32'h1);
    step(10);
    #1;
    chk("fo_ret",     32'(ret_en),  32'h2);
    chk("fo_ret_tag", 32'(ret_tag), 32'h077);
    step(1);

    // flush masks a request from the same lane in the same cycle (ptr=2)
    req_valid = 3'b011; flush = 1'b1; flush_lane = 3'b001;
    #1;
    chk("mask_other", 32'(req_ready), 32'h2);
    req_valid = 3'b001;
    #1;
    chk("mask_self", 32'(req_ready), 32'h0);
    idle_inputs();

    // reset in the middle of a double op on lane 0
    req_valid = 3'b001; req_dbl = 3'b001; req_tag0 = 14'h3FF;
    #1;
    chk("rm_ready", 32'(req_ready), 32'h1);
    step(1);
    idle_inputs();
    step(10);
    rst = 1'b0;
    #1;
    chk("rm_busy",  32'(busy),      32'h0);
    chk("rm_dbl",   32'(div_dbl),   32'h0);
    chk("rm_ret",   32'(ret_en),    32'h0);
    chk("rm_abort", 32'(div_abort), 32'h0);
    step(2);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      #1;
      if (ret_en != 3'b000 || busy != 1'b0 || div_abort != 1'b0) bad++;
    end
    chk("rm_no_stale", 32'(bad), 32'h0);
    req_valid = 3'b111;
    #1;
    chk("rm_ptr0", 32'(req_ready), 32'h1);
    idle_inputs();
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
